// File: rtl/branch_pkg.sv
// Shared definitions for the branch predict unit: BHT counter states,
// prediction-mode encodings and the default datapath width.
package branch_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Prediction-mode encodings for PREDICT_MODE.
    localparam int MODE_STATIC = 0;  // always predict not-taken, no table
    localparam int MODE_LAST   = 1;  // 1-bit last-outcome
    localparam int MODE_SAT2   = 2;  // 2-bit saturating counter

    // 2-bit counter states; the MSB is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,  // strong not-taken
        WNT = 2'b01,  // weak not-taken
        WT  = 2'b10,  // weak taken
        ST  = 2'b11   // strong taken
    } ctr_state_e;

endpackage

// File: rtl/sat_counter2.sv
// One BHT entry: a 2-bit saturating counter, or a last-outcome bit held in
// the MSB when ONE_BIT is set, so both predictor modes share one storage shape.
module sat_counter2
    import branch_pkg::*;
#(
    parameter bit ONE_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       taken,
    output logic [1:0] state
);

    localparam ctr_state_e RESET_STATE = ONE_BIT ? SNT : WNT;

    ctr_state_e state_q;
    ctr_state_e state_d;

    // Next state: record the outcome (1-bit) or step and saturate (2-bit).
    // NOTE: combinational blocks assign every output a default first and use
    // blocking '=', so no path leaves a value held and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (en) begin
            if (ONE_BIT) begin
                state_d = taken ? WT : SNT;
            end else begin
                unique case (state_q)
                    SNT: state_d = taken ? WNT : SNT;
                    WNT: state_d = taken ? WT  : SNT;
                    WT:  state_d = taken ? ST  : WNT;
                    ST:  state_d = taken ? ST  : WT;
                    default: state_d = RESET_STATE;
                endcase
            end
        end
    end

    // State register with asynchronous reset to the mode's initial value.
    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/branch_predict_unit.sv
// EX-stage branch resolution with a PC-indexed branch history table feeding
// the IF-stage prediction, plus redirect/flush generation and saturating
// branch/miss statistics.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int IDX_BITS     = 4,
    parameter int PREDICT_MODE = MODE_SAT2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [WIDTH-1:0]     IF_PC,
    output logic                 IF_PredictTaken,
    input  logic                 Stall,
    input  logic                 Branch,
    input  logic                 BEQ_BNE,
    input  logic                 Zero,
    input  logic                 JumpReg,
    input  logic                 BranchTaken,
    input  logic [WIDTH-1:0]     EX_PC,
    input  logic [WIDTH-1:0]     Imm,
    input  logic [WIDTH-1:0]     RegData,
    output logic                 ShouldBranch,
    output logic                 PredictionMiss,
    output logic                 Flush,
    output logic [WIDTH-1:0]     RedirectAddr,
    output logic [CNT_WIDTH-1:0] BranchCount,
    output logic [CNT_WIDTH-1:0] MissCount
);

    localparam int DEPTH = 2 ** IDX_BITS;

    logic             should_branch;
    logic             prediction_miss;
    logic             flush;
    logic [WIDTH-1:0] redirect_addr;
    logic [WIDTH-1:0] seq_pc;
    logic             bht_update;

    logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
    logic [CNT_WIDTH-1:0] miss_count_q,   miss_count_d;

    // Resolution and redirect: zero-latency; JumpReg dominates Branch.
    always_comb begin
        should_branch   = (Branch & (Zero ^ BEQ_BNE)) | JumpReg;
        prediction_miss = Branch & ~JumpReg & (should_branch ^ BranchTaken);
        flush           = prediction_miss | JumpReg;
        seq_pc          = EX_PC + WIDTH'(1);
        if (JumpReg) begin
            redirect_addr = RegData;
        end else if (prediction_miss && should_branch) begin
            redirect_addr = seq_pc + Imm;
        end else begin
            redirect_addr = seq_pc;
        end
    end

    // A resolved conditional branch trains the table and the counters unless EX is held.
    assign bht_update = Branch & ~JumpReg & ~Stall;

    // Statistics: count resolved branches and misses, holding at all-ones.
    always_comb begin
        branch_count_d = branch_count_q;
        miss_count_d   = miss_count_q;
        if (bht_update) begin
            if (!(&branch_count_q)) begin
                branch_count_d = branch_count_q + CNT_WIDTH'(1);
            end
            if (prediction_miss && !(&miss_count_q)) begin
                miss_count_d = miss_count_q + CNT_WIDTH'(1);
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            branch_count_q <= '0;
            miss_count_q   <= '0;
        end else begin
            branch_count_q <= branch_count_d;
            miss_count_q   <= miss_count_d;
        end
    end

    // Branch history table; mode 0 builds no storage at all.
    generate
        if (PREDICT_MODE == MODE_STATIC) begin : g_static
            logic [2*WIDTH+1:0] bht_inputs_unused;
            assign bht_inputs_unused = {IF_PC, EX_PC, bht_update, should_branch};
            assign IF_PredictTaken   = 1'b0;
        end else begin : g_bht
            logic [1:0]          entry_state [DEPTH];
            logic [IDX_BITS-1:0] wr_idx;
            logic [IDX_BITS-1:0] rd_idx;
            logic [WIDTH-IDX_BITS-1:0] if_pc_hi_unused;

            assign wr_idx          = EX_PC[IDX_BITS-1:0];
            assign rd_idx          = IF_PC[IDX_BITS-1:0];
            assign if_pc_hi_unused = IF_PC[WIDTH-1:IDX_BITS];

            // NOTE: the table is only 2**IDX_BITS flops deep, so each entry
            // takes the asynchronous reset like ordinary state; a RAM-backed
            // table could not be cleared this way.
            for (genvar i = 0; i < DEPTH; i++) begin : g_entry
                sat_counter2 #(
                    .ONE_BIT (PREDICT_MODE == MODE_LAST)
                ) u_ctr (
                    .clk   (Clk),
                    .rst_n (Reset_n),
                    .en    (bht_update && (wr_idx == IDX_BITS'(i))),
                    .taken (should_branch),
                    .state (entry_state[i])
                );
            end

            // IF read is a plain mux of the registered entries: no bypass of
            // a same-cycle EX write, and reset holds every MSB at 0.
            assign IF_PredictTaken = entry_state[rd_idx][1];
        end
    endgenerate

    assign ShouldBranch   = should_branch;
    assign PredictionMiss = prediction_miss;
    assign Flush          = flush;
    assign RedirectAddr   = redirect_addr;
    assign BranchCount    = branch_count_q;
    assign MissCount      = miss_count_q;

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the EX-stage branch unit. Resolves BEQ/BNE/JumpReg in EX, as before, and adds a PC-indexed branch history table (BHT) of saturating counters.
- The BHT supplies the IF-stage taken prediction and is trained when branches resolve in EX.
- Generates the redirect address and the pipeline flush, and keeps saturating branch/miss statistics counters.

Parameters:
WIDTH, 16, datapath/address width in bits
IDX_BITS, 4, BHT index width; table depth = 2**IDX_BITS
PREDICT_MODE, 2, 0 = static not-taken, 1 = 1-bit last-outcome, 2 = 2-bit saturating counter
CNT_WIDTH, 16, width of the statistics counters

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous active-low reset
IF_PC  in  WIDTH  address of the instruction being fetched
IF_PredictTaken  out  1  BHT prediction for IF_PC; forwarded down the pipe as BranchTaken
Stall  in  1  EX stage held; suppresses BHT update and counter increments
Branch  in  1  EX holds a conditional branch
BEQ_BNE  in  1  0 = BEQ (taken when Zero = 1), 1 = BNE (taken when Zero = 0)
Zero  in  1  ALU zero flag for the EX instruction
JumpReg  in  1  EX holds a register-indirect jump
BranchTaken  in  1  prediction made for this instruction in IF
EX_PC  in  WIDTH  address of the EX instruction
Imm  in  WIDTH  sign-extended branch offset
RegData  in  WIDTH  jump-register operand
ShouldBranch  out  1  resolved outcome
PredictionMiss  out  1  conditional branch mispredicted
Flush  out  1  squash the IF and ID stages
RedirectAddr  out  WIDTH  next fetch address when Flush = 1
BranchCount  out  CNT_WIDTH  resolved conditional branches
MissCount  out  CNT_WIDTH  mispredicted conditional branches

Behaviour:
- Resolution logic is combinational and has zero latency.
  - ShouldBranch = (Branch & (Zero ^ BEQ_BNE)) | JumpReg.
  - PredictionMiss = Branch & ~JumpReg & (ShouldBranch ^ BranchTaken).
  - Flush = PredictionMiss | JumpReg.
- RedirectAddr priority:
  - JumpReg: RegData.
  - Otherwise, a miss with ShouldBranch = 1: EX_PC + 1 + Imm.
  - Otherwise: EX_PC + 1.
  - All arithmetic is modulo 2**WIDTH; wrap-around is silent.
  - RedirectAddr is don't-care when Flush = 0 but must still be driven deterministically by the priority above.
- Branch and JumpReg both high is illegal. JumpReg dominates: no miss is reported and no BHT update occurs.
- The BHT is indexed by PC[IDX_BITS-1:0]. The IF read is combinational. IF_PredictTaken:
  - mode 0: constant 0.
  - mode 1: the stored bit.
  - mode 2: counter MSB.
- 2-bit counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Taken outcome increments; not-taken decrements.
  - Saturates at 11 and 00.
- 1-bit mode stores the last outcome.
- Update occurs at the rising edge when Branch & ~JumpReg & ~Stall. The entry at EX_PC index is written with the new state.
- Same-cycle IF read and EX write of the same index: IF sees the pre-update value. There is no bypass.
- In mode 0 the table is not implemented and no writes take effect.
- Statistics:
  - On an update edge, BranchCount increments, and MissCount increments if PredictionMiss = 1.
  - Both counters saturate at all-ones and never wrap.
- Reset (Reset_n low, asynchronous, valid at any time including mid-update):
  - Every BHT entry is set to 01 (mode 2) or 0 (mode 1).
  - BranchCount = MissCount = 0.
  - The combinational outputs follow their inputs throughout reset.
  - IF_PredictTaken = 0 during reset.
- Stall = 1 freezes all state. Combinational outputs remain valid.

Decomposition:
- Shared package `branch_pkg`:
  - counter-state constants (SNT, WNT, WT, ST).
  - PREDICT_MODE encodings.
  - the WIDTH default.
- Sub-module `sat_counter2` holds one 2-bit saturating counter with an enable and a taken/not-taken input. It is instantiated per BHT entry via generate (modes 1 and 2 share the storage array).
- The top level holds the resolution logic, redirect mux, and statistics counters.

Test Plan:
- Reset, then IF_PC = 0x0003 -> IF_PredictTaken = 0. Counts are 0.
- Branch = 1, BEQ_BNE = 0, Zero = 1, BranchTaken = 0, EX_PC = 0x0003, Imm = 0x000F -> ShouldBranch = 1, PredictionMiss = 1, Flush = 1, RedirectAddr = 0x0013.
  - After the edge, IF_PC = 0x0003 predicts taken (entry 10).
  - BranchCount = 1, MissCount = 1.
- Same branch resolved taken twice more -> entry 11. One not-taken resolution -> entry 10, still predicting taken.
  - The not-taken miss yields RedirectAddr = 0x0004.
- JumpReg = 1, RegData = 0xFFFF, Branch = 0 -> Flush = 1, PredictionMiss = 0, RedirectAddr = 0xFFFF. No BHT or count change.
- Stall = 1 with a mispredicted branch -> Flush = 1 is still asserted. BHT and counts are unchanged after the edge.
- Overflow: EX_PC = 0xFFFE, Imm = 0x0005, taken miss -> RedirectAddr = 0x0004.
- Reset_n pulsed low mid-cycle between edges -> all state clears immediately.
- With CNT_WIDTH = 2, five updates -> BranchCount holds at 3.
